// File: rtl/cic_pkg.sv
// Parameter limits and width helpers shared by the CIC decimator and its comb stages.
package cic_pkg;

    localparam int WIDTH_I_MIN = 4;
    localparam int WIDTH_I_MAX = 32;
    localparam int ORDER_MIN   = 1;
    localparam int ORDER_MAX   = 6;
    localparam int R_MIN       = 2;
    localparam int R_MAX       = 64;
    localparam int M_MIN       = 1;
    localparam int M_MAX       = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Bit growth of a CIC is ORDER*log2(R*M) on top of the input width.
    function automatic int cic_out_width(input int widthIn, input int order,
                                         input int r, input int m);
        return widthIn + order * clog2(r * m);
    endfunction

    function automatic bit cic_params_ok(input int widthIn, input int order,
                                         input int r, input int m);
        return (widthIn >= WIDTH_I_MIN) && (widthIn <= WIDTH_I_MAX) &&
               (order >= ORDER_MIN) && (order <= ORDER_MAX) &&
               (r >= R_MIN) && (r <= R_MAX) &&
               (m >= M_MIN) && (m <= M_MAX);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section running at the decimated rate: out = in - in delayed by M decimated samples.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int width = 16,
    parameter int M     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] i_data,
    input  logic             i_valid,
    output logic [width-1:0] o_data,
    output logic             o_valid
);

    if ((M < M_MIN) || (M > M_MAX)) begin : gBadM
        $error("cic_comb_stage: M=%0d outside %0d..%0d", M, M_MIN, M_MAX);
    end

    logic [width-1:0] r_delay [M];
    logic [width-1:0] r_data;
    logic             r_valid;

    // The delay line only moves on decimated samples, so M counts output-rate samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                r_delay[i] <= '0;
            end
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_delay[0] <= i_data;
                for (int i = 1; i < M; i++) begin
                    r_delay[i] <= r_delay[i-1];
                end
                r_data <= i_data - r_delay[M-1];
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/cic_decim.sv
// CIC decimator: ORDER inline integrators, 1-in-R decimation, ORDER comb stages at the low rate.
module cic_decim
    import cic_pkg::*;
#(
    parameter  int width_I = 16,
    parameter  int ORDER   = 3,
    parameter  int R       = 8,
    parameter  int M       = 1,
    localparam int width_O = cic_out_width(width_I, ORDER, R, M)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_i_en,
    input  logic [width_I-1:0] data_i,
    output logic               data_o_en,
    output logic [width_O-1:0] data_o
);

    if (!cic_params_ok(width_I, ORDER, R, M)) begin : gBadParams
        $error("cic_decim: illegal parameters width_I=%0d ORDER=%0d R=%0d M=%0d",
               width_I, ORDER, R, M);
    end

    localparam int CNT_W = clog2(R);

    logic [width_O-1:0] w_dataExt;
    logic [width_O-1:0] r_intAcc [ORDER];
    logic [ORDER-1:0]   r_intValid;
    logic [CNT_W-1:0]   r_phase;
    logic [width_O-1:0] r_decim;
    logic               r_decValid;
    logic [width_O-1:0] w_combData [ORDER+1];
    logic [ORDER:0]     w_combValid;

    assign w_dataExt = {{(width_O - width_I){data_i[width_I-1]}}, data_i};

    // Integrators wrap modulo 2^width_O by design; the combs cancel the wrap exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                r_intAcc[k] <= '0;
            end
            r_intValid <= '0;
        end else begin
            r_intValid[0] <= data_i_en;
            if (data_i_en) begin
                r_intAcc[0] <= r_intAcc[0] + w_dataExt;
            end
            for (int k = 1; k < ORDER; k++) begin
                r_intValid[k] <= r_intValid[k-1];
                if (r_intValid[k-1]) begin
                    r_intAcc[k] <= r_intAcc[k] + r_intAcc[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_decim    <= '0;
            r_decValid <= 1'b0;
        end else begin
            r_decValid <= 1'b0;
            if (r_intValid[ORDER-1]) begin
                if (r_phase == CNT_W'(R - 1)) begin
                    r_phase    <= '0;
                    r_decim    <= r_intAcc[ORDER-1];
                    r_decValid <= 1'b1;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end
        end
    end

    assign w_combData[0]  = r_decim;
    assign w_combValid[0] = r_decValid;

    for (genvar j = 0; j < ORDER; j++) begin : gComb
        cic_comb_stage #(
            .width (width_O),
            .M     (M)
        ) uComb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_data  (w_combData[j]),
            .i_valid (w_combValid[j]),
            .o_data  (w_combData[j+1]),
            .o_valid (w_combValid[j+1])
        );
    end

    assign data_o    = w_combData[ORDER];
    assign data_o_en = w_combValid[ORDER];

endmodule

// File: tb/tb_cic_decim.sv
// Randomized and directed bench for cic_decim; two instances (M=1, M=2) share one stimulus stream.
module tb_cic_decim;

    localparam int RR   = 4;
    localparam int ORD0 = 3;
    localparam int ORD1 = 2;
    localparam int M0   = 1;
    localparam int M1   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_i_en;
    logic [7:0]  data_i;
    logic        en0, en1;
    logic [13:0] do0, do1;

    cic_decim #(.width_I(8), .ORDER(ORD0), .R(RR), .M(M0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i_en (data_i_en),
        .data_i    (data_i),
        .data_o_en (en0),
        .data_o    (do0)
    );

    cic_decim #(.width_I(8), .ORDER(ORD1), .R(RR), .M(M1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i_en (data_i_en),
        .data_i    (data_i),
        .data_o_en (en1),
        .data_o    (do1)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint at;
        longint val;
    } expT;

    int     compared   = 0;
    int     mismatched = 0;
    bit     checking   = 1'b0;
    longint edgeIdx    = 0;
    longint h0 [64];
    longint h1 [64];
    int     len0, len1;
    longint hist [$];
    int     acceptCount = 0;
    expT    q0 [$];
    expT    q1 [$];
    longint held0 = 0;
    longint held1 = 0;
    longint pulseEdges [$];

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (edge %0d)", tag, observed, expected, edgeIdx);
        end
    endtask

    // Impulse response of the whole filter: ORDER-fold convolution of an R*M boxcar.
    function automatic longint coefAt(input int order, input int rm, input int k);
        longint cur [64];
        longint nxt [64];
        for (int i = 0; i < 64; i++) cur[i] = 0;
        cur[0] = 1;
        for (int n = 0; n < order; n++) begin
            for (int i = 0; i < 64; i++) nxt[i] = 0;
            for (int i = 0; i < 64; i++) begin
                for (int j = 0; j < rm; j++) begin
                    if (i + j < 64) nxt[i+j] += cur[i];
                end
            end
            cur = nxt;
        end
        return cur[k];
    endfunction

    // Output after the newest accepted sample = FIR of the accepted history, mod 2^14.
    function automatic longint firOut(input int which);
        longint acc;
        int     m;
        int     len;
        logic [13:0] t;
        acc = 0;
        m   = hist.size() - 1;
        len = (which == 0) ? len0 : len1;
        for (int k = 0; k < len; k++) begin
            if (k <= m) acc += ((which == 0) ? h0[k] : h1[k]) * hist[m-k];
        end
        t = acc[13:0];
        return longint'($signed(t));
    endfunction

    always @(posedge clk) begin
        edgeIdx++;
        if (!rst_n) begin
            hist.delete();
            acceptCount = 0;
            q0.delete();
            q1.delete();
            held0 = 0;
            held1 = 0;
        end else if (data_i_en) begin
            hist.push_back(longint'($signed(data_i)));
            if (hist.size() > 64) void'(hist.pop_front());
            acceptCount++;
            if (acceptCount % RR == 0) begin
                q0.push_back('{edgeIdx + 2 * ORD0, firOut(0)});
                q1.push_back('{edgeIdx + 2 * ORD1, firOut(1)});
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin : monitor
            logic e0x, e1x;
            e0x = (q0.size() > 0) && (q0[0].at == edgeIdx);
            e1x = (q1.size() > 0) && (q1[0].at == edgeIdx);
            if (e0x) begin
                held0 = q0[0].val;
                void'(q0.pop_front());
            end
            if (e1x) begin
                held1 = q1[0].val;
                void'(q1.pop_front());
            end
            checkOutput("en0", longint'(en0), longint'(e0x));
            checkOutput("data0", longint'($signed(do0)), held0);
            checkOutput("en1", longint'(en1), longint'(e1x));
            checkOutput("data1", longint'($signed(do1)), held1);
            if (en0) pulseEdges.push_back(edgeIdx);
        end
    end

    task automatic applyStimulus(input logic rstv, input logic en, input logic [7:0] d);
        rst_n     = rstv;
        data_i_en = en;
        data_i    = d;
        @(negedge clk);
        #1;
    endtask

    function automatic longint lastPeriod();
        int n;
        n = pulseEdges.size();
        return (n >= 2) ? pulseEdges[n-1] - pulseEdges[n-2] : -1;
    endfunction

    function automatic longint firstPulse();
        return (pulseEdges.size() > 0) ? pulseEdges[0] : -1000;
    endfunction

    longint e0, rstEdge;

    initial begin
        for (int k = 0; k < 64; k++) begin
            h0[k] = coefAt(ORD0, RR * M0, k);
            h1[k] = coefAt(ORD1, RR * M1, k);
        end
        len0 = ORD0 * (RR * M0 - 1) + 1;
        len1 = ORD1 * (RR * M1 - 1) + 1;

        applyStimulus(1'b0, 1'b1, 8'd5);
        checking = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'd7);
        checkOutput("rstEn0", longint'(en0), 0);
        checkOutput("rstData0", longint'($signed(do0)), 0);
        checkOutput("rstEn1", longint'(en1), 0);
        checkOutput("rstData1", longint'($signed(do1)), 0);

        // Latency: four back-to-back samples straight out of reset.
        pulseEdges.delete();
        applyStimulus(1'b1, 1'b1, 8'd1);
        e0 = edgeIdx;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        checkOutput("latencyCycle", firstPulse() - e0 + 1, 10);
        checkOutput("latencyCount", longint'(pulseEdges.size()), 1);

        // DC gain with continuous input.
        pulseEdges.delete();
        for (int i = 0; i < 200; i++) applyStimulus(1'b1, 1'b1, 8'd1);
        checkOutput("dcValue0", longint'($signed(do0)), 64);
        checkOutput("dcValue1", longint'($signed(do1)), 64);
        checkOutput("dcPeriod", lastPeriod(), 4);

        // One-cycle reset in the middle of the DC run.
        applyStimulus(1'b0, 1'b1, 8'd1);
        rstEdge = edgeIdx;
        checkOutput("midRstEn0", longint'(en0), 0);
        checkOutput("midRstData0", longint'($signed(do0)), 0);
        checkOutput("midRstData1", longint'($signed(do1)), 0);
        pulseEdges.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 8'd1);
        checkOutput("rstRecover", firstPulse() - rstEdge, 10);

        // Sparse input: one valid sample in three, junk data on idle cycles.
        pulseEdges.delete();
        for (int i = 0; i < 300; i++) begin
            if (i % 3 == 0) applyStimulus(1'b1, 1'b1, 8'd1);
            else            applyStimulus(1'b1, 1'b0, 8'($urandom));
        end
        checkOutput("sparseValue0", longint'($signed(do0)), 64);
        checkOutput("sparseValue1", longint'($signed(do1)), 64);
        checkOutput("sparsePeriod", lastPeriod(), 12);

        // Full-scale negative input long enough for the integrators to wrap many times.
        pulseEdges.delete();
        for (int i = 0; i < 17000; i++) applyStimulus(1'b1, 1'b1, 8'h80);
        checkOutput("fullScale0", longint'($signed(do0)), -8192);
        checkOutput("fullScale1", longint'($signed(do1)), -8192);
        checkOutput("fullScalePeriod", lastPeriod(), 4);

        // Random data, random gaps and occasional resets, checked cycle by cycle.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'd0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cic_decim.md
CIC_DECIM -- requirements
Module: cic_decim

Interface
REQ-001 SHALL have parameter width_I, default 16: input sample width, two's complement, range 4..32.
REQ-002 SHALL have parameter ORDER, default 3: number of integrator and comb stages, range 1..6.
REQ-003 SHALL have parameter R, default 8: decimation ratio, range 2..64.
REQ-004 SHALL have parameter M, default 1: differential delay, allowed values 1 or 2.
REQ-005 SHALL derive localparam width_O = width_I + ORDER*clog2(R*M) using the package function.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port data_i_en, input, 1 bit: input sample valid.
REQ-009 SHALL have port data_i, input, width_I bits: input sample.
REQ-010 SHALL have port data_o_en, output, 1 bit: one-cycle pulse per decimated output sample.
REQ-011 SHALL have port data_o, output, width_O bits: decimated output sample, full precision, no truncation.

Function
REQ-012 SHALL sign-extend data_i to width_O bits before the first integrator.
REQ-013 SHALL perform all integrator and comb arithmetic modulo 2^width_O; wrap-around is required behaviour and is never saturated or flagged.
REQ-014 SHALL build the integrator chain from ORDER registered stages with a valid bit per stage.
REQ-015 SHALL update integrator stage k (acc_k <= acc_k + in_k) only in a cycle where its incoming valid is 1; otherwise it SHALL hold.
REQ-016 SHALL carry a sample accepted at cycle t (data_i_en=1) to the output of the last integrator at cycle t+ORDER.
REQ-017 SHALL keep a phase counter 0..R-1 that advances on each valid leaving the last integrator and wraps from R-1 to 0.
REQ-018 SHALL, when the counter is at R-1 and that valid arrives, capture the last integrator output into the decimation register (valid at t+ORDER+1); all other valids are discarded.
REQ-019 SHALL give each comb stage j an M-deep delay line, shifted only on its decimated valid: out_j = in_j - in_j delayed by M decimated samples, registered.
REQ-020 SHALL drive data_o from the last comb register and assert data_o_en at t+2*ORDER+1, where t is the cycle of the R-th accepted input.
REQ-021 SHALL make latency independent of gaps in data_i_en; idle cycles stall nothing already in flight, and the pipeline drains at one stage per cycle.
REQ-022 SHALL accept back-to-back data_i_en (one sample per cycle) indefinitely with no stall and no sample loss.
REQ-023 SHALL hold data_o between pulses; data_o_en SHALL never be high on two consecutive cycles.
REQ-024 SHALL produce steady-state DC gain (R*M)^ORDER, which exactly fits width_O for full-scale input.
REQ-025 SHALL raise an elaboration-time error for any parameter outside the ranges in REQ-001..REQ-004.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear all integrators, comb delay lines, comb registers, the decimation register, the phase counter, all valid bits, data_o and data_o_en to 0.
REQ-027 SHALL ignore data_i_en while rst_n=0, and SHALL discard any sample in flight when reset is asserted mid-operation.
REQ-028 SHALL, after reset release, emit its first data_o_en only after R new accepted samples, at the latency given in REQ-020.

Structure
REQ-029 SHALL place the clog2 and cic_out_width functions and the parameter range limits in package cic_pkg.
REQ-030 SHALL implement the comb stage as sub-module cic_comb_stage (params: width, M), instantiated ORDER times in a generate loop; integrators are inline.

Verification
REQ-031 SHALL check DC: width_I=8, ORDER=3, R=4, M=1, data_i=1 every cycle -> data_o settles to 64 and data_o_en pulses every 4 cycles.
REQ-032 SHALL check full scale: same config, data_i=-128 continuous -> data_o settles to -8192 (width_O=14), with correct values across more than 2^14 cycles despite internal integrator wrap.
REQ-033 SHALL check sparse input: data_i=1 with data_i_en high one cycle in three -> same settled value 64, with data_o_en every 12 cycles.
REQ-034 SHALL check latency: after reset, 4 back-to-back samples starting at cycle 0 -> first data_o_en at cycle 3+7=10.
REQ-035 SHALL check mid-operation reset: assert rst_n=0 for one cycle during the DC run -> all outputs 0 next cycle, then the next data_o_en only after 4 new samples.
REQ-036 SHALL check M=2: ORDER=2, R=4, data_i=1 -> data_o settles to 64.
